// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit for the bus-based register datapath.
// Fetches through a memory read handshake, decodes IR and drives every
// register-enable, bus-drive and ALU-select strobe of the datapath.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for run
//   T0     | PC -> MAR, Z <= PC+1
//   T1     | Z -> PC (first cycle only), memory read until mem_done
//   T2     | MDR -> IR
//   T3     | first execute step (operand to Y, or single-step ops)
//   T4     | second operand, ALU/immediate into Z
//   T5     | Z low -> destination (or LO for mul)
//   T6     | Z high -> HI (mul only)
//   HALT   | stopped until clear
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        mem_done,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        Yin,
    output logic        Yout,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MARin,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        IncPC,
    output logic        Cout,
    output logic        Read,
    output logic [3:0]  alu_op,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_MUL = 4'd4;

    state_t     state, state_nxt;
    logic       t1_first;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_addi, is_mul, is_mfhi, is_mflo, is_nop, is_halt;
    logic       is_legal;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    // Immediate bits go straight to the datapath's sign extender, not here.
    assign unused_ir = ^IR[14:0];

    assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_addi  = (op == OP_ADDI);
    assign is_mul   = (op == OP_MUL);
    assign is_mfhi  = (op == OP_MFHI);
    assign is_mflo  = (op == OP_MFLO);
    assign is_nop   = (op == OP_NOP);
    assign is_halt  = (op == OP_HALT);
    assign is_legal = is_alu || is_addi || is_mul || is_mfhi || is_mflo || is_nop || is_halt;

    // State register; t1_first marks the T1 cycle entered straight from T0
    // so wait states never reload PC.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state    <= S_IDLE;
            t1_first <= 1'b0;
        end else begin
            state    <= state_nxt;
            t1_first <= (state == S_T0);
        end
    end

    // Next-state and Moore strobe decode (IR fields qualify T3..T6).
    always_comb begin
        state_nxt = state;
        Rin       = '0;
        Rout      = '0;
        PCin      = 1'b0;
        PCout     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Yout      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        HIin      = 1'b0;
        HIout     = 1'b0;
        LOin      = 1'b0;
        LOout     = 1'b0;
        Zlowin    = 1'b0;
        Zhighin   = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        IncPC     = 1'b0;
        Cout      = 1'b0;
        Read      = 1'b0;
        alu_op    = ALU_ADD;
        busy      = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_T0;
            end
            S_T0: begin
                busy      = 1'b1;
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zlowin    = 1'b1;
                Zhighin   = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                PCin    = t1_first;
                Read    = 1'b1;
                MDRin   = mem_done;
                if (mem_done) state_nxt = S_T2;
            end
            S_T2: begin
                busy      = 1'b1;
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                busy      = 1'b1;
                illegal   = !is_legal;
                state_nxt = S_T0;
                if (is_alu || is_addi) begin
                    Rout      = 16'd1 << rb;
                    Yin       = 1'b1;
                    state_nxt = S_T4;
                end else if (is_mul) begin
                    Rout      = 16'd1 << ra;
                    Yin       = 1'b1;
                    state_nxt = S_T4;
                end else if (is_mfhi) begin
                    HIout = 1'b1;
                    Rin   = 16'd1 << ra;
                end else if (is_mflo) begin
                    LOout = 1'b1;
                    Rin   = 16'd1 << ra;
                end else if (is_halt) begin
                    state_nxt = S_HALT;
                end
            end
            S_T4: begin
                busy      = 1'b1;
                Zlowin    = 1'b1;
                Zhighin   = 1'b1;
                state_nxt = S_T5;
                if (is_addi) begin
                    Cout = 1'b1;
                end else if (is_mul) begin
                    Rout   = 16'd1 << rb;
                    alu_op = ALU_MUL;
                end else begin
                    Rout = 16'd1 << rc;
                    case (op)
                        OP_SUB:  alu_op = ALU_SUB;
                        OP_AND:  alu_op = ALU_AND;
                        OP_OR:   alu_op = ALU_OR;
                        default: alu_op = ALU_ADD;
                    endcase
                end
            end
            S_T5: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                if (is_mul) begin
                    LOin      = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    Rin       = 16'd1 << ra;
                    state_nxt = S_T0;
                end
            end
            S_T6: begin
                busy      = 1'b1;
                Zhighout  = 1'b1;
                HIin      = 1'b1;
                state_nxt = S_T0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction strobe traces
// from a reference model, a latency table, and directed reset/halt cases.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] IR;
    logic        mem_done;
    logic [15:0] Rin, Rout;
    logic PCin, PCout, IRin, Yin, Yout, MDRin, MDRout, MARin;
    logic HIin, HIout, LOin, LOout, Zlowin, Zhighin, Zlowout, Zhighout;
    logic IncPC, Cout, Read, busy, halted, illegal;
    logic [3:0]  alu_op;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcin, pcout, irin, yin, yout, mdrin, mdrout, marin;
        logic hiin, hiout, loin, loout, zlowin, zhighin, zlowout, zhighout;
        logic incpc, cout, read;
        logic [3:0] alu_op;
        logic busy, halted, illegal;
    } obs_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        int          lat;
        logic [15:0] rin;
        int          ill;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    obs_t cur;
    obs_t exp_q[$];
    bit   t0_pending = 0;

    localparam logic [31:0] ADD_IR  = 32'h1911_8000;
    localparam logic [31:0] HALT_IR = 32'hD800_0000;
    localparam logic [31:0] NOP_IR  = 32'hD000_0000;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .IR(IR), .mem_done(mem_done),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IRin(IRin),
        .Yin(Yin), .Yout(Yout), .MDRin(MDRin), .MDRout(MDRout), .MARin(MARin),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .IncPC(IncPC), .Cout(Cout), .Read(Read), .alu_op(alu_op),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic compare(input string name, input obs_t act, input obs_t expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s @%0t: got %h required %h", name, $time, act, expv);
        end
    endtask

    // Drive inputs at the falling edge, sample 1 time unit later, and check
    // the bus-exclusivity invariant on every sampled cycle.
    task automatic step(input logic r, input logic md, input logic clr, input logic [31:0] irv);
        int drivers;
        @(negedge clock);
        run = r; mem_done = md; clear = clr; IR = irv;
        #1;
        cur = '{Rin, Rout, PCin, PCout, IRin, Yin, Yout, MDRin, MDRout, MARin,
                HIin, HIout, LOin, LOout, Zlowin, Zhighin, Zlowout, Zhighout,
                IncPC, Cout, Read, alu_op, busy, halted, illegal};
        drivers = $countones(Rout) + int'(PCout) + int'(Yout) + int'(MDRout) + int'(HIout)
                + int'(LOout) + int'(Zlowout) + int'(Zhighout) + int'(Cout);
        checks++;
        if (drivers > 1 || $countones(Rin) > 1) begin
            failures++;
            $display("FAIL bus_exclusive @%0t: drivers=%0d rin=%h required drivers<=1 rin onehot0",
                     $time, drivers, Rin);
        end
    endtask

    function automatic obs_t busy_obs();
        obs_t o;
        o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    // Reference model: list of expected per-cycle strobes for one instruction
    // from its T0 through its last execute step.
    function automatic void push_instr(input logic [31:0] ir, input int waits);
        obs_t o;
        logic [4:0] op;
        logic [3:0] ra, rb, rc, code;
        bit three_step;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        o = busy_obs(); o.pcout = 1; o.marin = 1; o.incpc = 1; o.zlowin = 1; o.zhighin = 1;
        exp_q.push_back(o);
        for (int w = 0; w <= waits; w++) begin
            o = busy_obs(); o.zlowout = 1; o.read = 1;
            o.pcin  = (w == 0);
            o.mdrin = (w == waits);
            exp_q.push_back(o);
        end
        o = busy_obs(); o.mdrout = 1; o.irin = 1;
        exp_q.push_back(o);
        three_step = 1;
        code = 4'd0;
        case (op)
            5'b00011: code = 4'd0;
            5'b00100: code = 4'd1;
            5'b00101: code = 4'd2;
            5'b00110: code = 4'd3;
            5'b01100: code = 4'd0;
            default:  three_step = 0;
        endcase
        if (three_step) begin
            o = busy_obs(); o.rout = 16'd1 << rb; o.yin = 1; exp_q.push_back(o);
            o = busy_obs(); o.zlowin = 1; o.zhighin = 1; o.alu_op = code;
            if (op == 5'b01100) o.cout = 1; else o.rout = 16'd1 << rc;
            exp_q.push_back(o);
            o = busy_obs(); o.zlowout = 1; o.rin = 16'd1 << ra; exp_q.push_back(o);
        end else if (op == 5'b01111) begin
            o = busy_obs(); o.rout = 16'd1 << ra; o.yin = 1; exp_q.push_back(o);
            o = busy_obs(); o.rout = 16'd1 << rb; o.alu_op = 4'd4; o.zlowin = 1; o.zhighin = 1;
            exp_q.push_back(o);
            o = busy_obs(); o.zlowout = 1; o.loin = 1; exp_q.push_back(o);
            o = busy_obs(); o.zhighout = 1; o.hiin = 1; exp_q.push_back(o);
        end else if (op == 5'b10111) begin
            o = busy_obs(); o.hiout = 1; o.rin = 16'd1 << ra; exp_q.push_back(o);
        end else if (op == 5'b11000) begin
            o = busy_obs(); o.loout = 1; o.rin = 16'd1 << ra; exp_q.push_back(o);
        end else if (op == 5'b11010 || op == 5'b11011) begin
            exp_q.push_back(busy_obs());
        end else begin
            o = busy_obs(); o.illegal = 1; exp_q.push_back(o);
        end
    endfunction

    // Runs one instruction starting from its T0 cycle and compares every cycle.
    task automatic exec(input string name, input logic [31:0] ir, input int waits);
        int n;
        logic md;
        exp_q.delete();
        push_instr(ir, waits);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == 1 + waits)          md = 1'b1;
            else if (i >= 1 && i <= waits) md = 1'b0;
            else                         md = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), md, 1'b1, (i >= 2 + waits) ? ir : $urandom);
            compare(name, cur, exp_q[i]);
        end
    endtask

    // Counts cycles from this instruction's T0 until the next T0 appears.
    task automatic measure(input logic [31:0] ir, input int waits,
                           output int lat, output logic [15:0] rin_or, output int ill);
        logic md;
        bit   done;
        lat = 0; rin_or = '0; ill = 0; done = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(i == 0 && t0_pending)) begin
                if (i == 1 + waits)          md = 1'b1;
                else if (i >= 1 && i <= waits) md = 1'b0;
                else                         md = 1'($urandom_range(0, 1));
                step(1'($urandom_range(0, 1)), md, 1'b1, (i >= 2 + waits) ? ir : $urandom);
            end
            if (i > 0 && cur.pcout && cur.marin) begin
                lat = i;
                done = 1;
                break;
            end
            rin_or |= cur.rin;
            ill += int'(cur.illegal);
        end
        t0_pending = done;
        if (!done) begin
            failures++;
            $display("FAIL latency_timeout: ir=%h no next T0 within 40 cycles", ir);
        end
    endtask

    initial begin
        vec_t        tbl[10];
        int          lat, ill;
        logic [15:0] rin_or;
        obs_t        zero_o, halt_o;
        logic [4:0]  rop;
        logic [31:0] rir;

        tbl[0] = '{ADD_IR,        0, 6, 16'h0004, 0};
        tbl[1] = '{ADD_IR,        3, 9, 16'h0004, 0};
        tbl[2] = '{32'h7A28_0000, 0, 7, 16'h0000, 0};
        tbl[3] = '{32'h6388_0123, 0, 6, 16'h0080, 0};
        tbl[4] = '{32'hBC80_0000, 0, 4, 16'h0200, 0};
        tbl[5] = '{32'hC780_0000, 2, 6, 16'h8000, 0};
        tbl[6] = '{NOP_IR,        0, 4, 16'h0000, 0};
        tbl[7] = '{32'hF800_0000, 0, 4, 16'h0000, 1};
        tbl[8] = '{32'hF800_0000, 1, 5, 16'h0000, 1};
        tbl[9] = '{32'h207F_0000, 0, 6, 16'h0001, 0};

        zero_o = '0;
        halt_o = '0;
        halt_o.halted = 1'b1;

        clear = 1'b0; run = 1'b0; mem_done = 1'b0; IR = '0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        compare("reset_state", cur, zero_o);
        step(1'b0, 1'b1, 1'b1, 32'h0);
        compare("idle_no_run", cur, zero_o);
        step(1'b1, 1'b0, 1'b1, 32'h0);
        compare("idle_run", cur, zero_o);

        // Latency / destination / illegal table, back to back from T0.
        for (int k = 0; k < 10; k++) begin
            measure(tbl[k].ir, tbl[k].waits, lat, rin_or, ill);
            checks++;
            if (lat != tbl[k].lat || rin_or !== tbl[k].rin || ill != tbl[k].ill) begin
                failures++;
                $display("FAIL table[%0d]: lat=%0d rin=%h illegal=%0d required lat=%0d rin=%h illegal=%0d",
                         k, lat, rin_or, ill, tbl[k].lat, tbl[k].rin, tbl[k].ill);
            end
        end

        // Reset lands in T1 of the pending fetch; Read must drop.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        t0_pending = 0;
        step(1'b1, 1'b1, 1'b1, 32'h0);
        compare("reset_mid_fetch", cur, zero_o);

        // Random instruction stream against the reference model.
        for (int k = 0; k < 40; k++) begin
            rop = 5'($urandom_range(0, 31));
            if (rop == 5'b11011) rop = 5'b00011;
            rir = {rop, 27'($urandom)};
            exec("random_trace", rir, $urandom_range(0, 3));
        end

        // Reset in T4 of an add, then restart.
        exp_q.delete();
        push_instr(ADD_IR, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i == 1), (i == 4) ? 1'b0 : 1'b1, (i >= 2) ? ADD_IR : $urandom);
            compare("add_before_reset", cur, exp_q[i]);
        end
        step(1'b0, 1'b0, 1'b1, ADD_IR);
        compare("reset_mid_t4", cur, zero_o);
        step(1'b1, 1'b0, 1'b1, ADD_IR);
        compare("restart_idle", cur, zero_o);
        exec("add_after_reset", ADD_IR, 0);

        // Halt is absorbing, ignores run, and only clear leaves it.
        exec("halt_fetch", HALT_IR, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, HALT_IR);
            compare("halted_state", cur, halt_o);
        end
        step(1'b0, 1'b0, 1'b0, HALT_IR);
        step(1'b1, 1'b0, 1'b1, 32'h0);
        compare("halt_cleared", cur, zero_o);
        exec("nop_after_halt", NOP_IR, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
